srp_out_buff_ctrl: RTL
======================

# srp_out_buff_ctrl

- Sequencer for the 768×8 Shapiro-Rudin-Park output buffer BRAM (1-cycle registered read, write-first, output held while `en`=0).
- Accepts one frame of `DEPTH` bytes from the time synchronizer into the BRAM, then streams it back out on a valid/ready interface at up to one byte per clock.
- Sits between the SRP time-synchronizer datapath and the downstream demodulator; it is the only master of the buffer's `en/we/addr/di` port.

## Interface
- `DEPTH`, 768: bytes per frame; must be ≤ 2^`AW`.
- `AW`, 10: BRAM address width.
- `DW`, 8: data width.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse; arms a fill (honoured in IDLE only).
- `abort` in 1: returns to IDLE from any state; takes priority over everything except reset.
- `in_valid` in 1, `in_data` in DW, `in_ready` out 1: write-side handshake.
- `out_valid` out 1, `out_data` out DW, `out_ready` in 1: read-side handshake.
- `busy` out 1: high in FILL or DRAIN.
- `frame_done` out 1: one-cycle pulse after the last byte is accepted downstream.
- `bram_en` out 1, `bram_we` out 1, `bram_addr` out AW, `bram_di` out DW: BRAM port drive.
- `bram_dout` in DW: BRAM read data.
- `drop_cnt` out 16: present only with `SRP_BUFF_DROP_CNT_EN`.

## Operation
States: IDLE, FILL, DRAIN, DONE.

**IDLE**
- `start`=1 → FILL; `wr_ptr`=0.

**FILL**
- `in_ready`=1.
- Each cycle with `in_valid`: `bram_en`=1, `bram_we`=1, `bram_addr`=`wr_ptr`, `bram_di`=`in_data`; then `wr_ptr`++.
- The write at `wr_ptr`=`DEPTH`-1 → DRAIN next cycle; `rd_ptr`=0.

**DRAIN**
- A read is issued in a cycle iff `rd_ptr`<`DEPTH` and (`out_valid`=0 or `out_ready`=1).
- Issuing a read drives `bram_en`=1, `bram_we`=0, `bram_addr`=`rd_ptr`; then `rd_ptr`++.
- `out_data` = `bram_dout` combinationally.
- `out_valid` register: next = (read issued) or (`out_valid` and not `out_ready`).
- While a byte is stalled, `bram_en`=0, so `bram_dout` holds it stable.
- When the last byte (address `DEPTH`-1) is accepted (`out_valid`&`out_ready`) → DONE.
- The `out_ready`→`bram_en` path is combinational by design.

**DONE**
- `frame_done`=1 for one cycle → IDLE.

**Common rules**
- Outside FILL: `in_ready`=0. Outside DRAIN: `out_valid`=0.
- Outside the issuing cycles: `bram_en`=0, `bram_we`=0; `bram_addr` and `bram_di` are 0.
- `abort` in any state: next state IDLE, pointers 0, `out_valid` 0, no `frame_done`.
- `start` outside IDLE: ignored.
- `start`+`abort` together in IDLE: abort wins, so the block stays in IDLE.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state IDLE;
  - `wr_ptr`, `rd_ptr` 0;
  - `in_ready`, `out_valid`, `busy`, `frame_done`, `bram_en`, `bram_we` = 0;
  - `bram_addr`, `bram_di` = 0;
  - `drop_cnt` 0.
- Reset mid-frame discards the frame. The BRAM contents are not cleared.
- `start` sampled at edge k → `in_ready`=1 from cycle k+1.
- Last FILL write at edge f → DRAIN from cycle f+1:
  - read of address 0 issued in cycle f+1;
  - `out_valid`=1 with byte 0 in cycle f+2.
- With `out_ready` held high: bytes 0..767 appear on cycles f+2 .. f+769, one per cycle, no bubbles.
- Last accept at edge d → `frame_done`=1 in cycle d+1 → IDLE (`busy`=0) in cycle d+2.
- Back-pressure: a byte presented while `out_ready`=0 stays unchanged on `out_data`; no read is issued until it is accepted.
- Minimum frame period at full rate: 1 (start) + 768 (fill) + 1 (DRAIN read issue) + 768 (drain) + 1 (DONE) cycles.

## Configuration
- `SRP_BUFF_DROP_CNT_EN` defined:
  - `drop_cnt` port exists;
  - it increments once per cycle with `in_valid`=1 while not in FILL, saturating at 16'hFFFF;
  - it is cleared only by reset.
- Not defined: the port and counter are absent; `in_valid` outside FILL is silently ignored.
- Core behaviour is identical either way.

## Test plan
- **Full frame:** reset, `start`, feed bytes `i[7:0]` for i=0..767 with `in_valid` held high, `out_ready`=1 → `out_data` sequence 0x00..0xFF repeated three times, first byte at f+2, single `frame_done` pulse, then `busy`=0.
- **Back-pressure:** during DRAIN, toggle `out_ready` on a 1-of-3 pattern → every byte delivered exactly once, in order; `out_data` stable while `out_valid`&!`out_ready`; `bram_en`=0 during stalls.
- **Gapped input:** `in_valid` random 50% during FILL → exactly 768 writes at addresses 0..767; DRAIN entered only after address 767.
- **Abort:** abort mid-FILL at byte 300, then abort mid-DRAIN at byte 500 → IDLE next cycle, `out_valid`=0, no `frame_done`; a fresh `start` then completes a full frame correctly.
- **Reset and ignored start:** `rst_n`=0 during DRAIN → all outputs at reset values next cycle; `start` asserted during FILL has no effect.
- **Drop counter** (`SRP_BUFF_DROP_CNT_EN` defined): 5 `in_valid` cycles in IDLE plus 3 in DRAIN → `drop_cnt`=8.

Source files
------------

// File: rtl/srp_out_buff_ctrl.sv
// -----------------------------------------------------------------------------
// srp_out_buff_ctrl
//
// Sequencer for the Shapiro-Rudin-Park output buffer BRAM (registered 1-cycle
// read, write-first, read data held while en=0). Captures one frame of DEPTH
// bytes from the time synchronizer, then streams it to the demodulator over a
// valid/ready interface at up to one byte per clock. This block is the only
// master of the BRAM en/we/addr/di port.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   start                 one-cycle pulse, arms a fill (IDLE only)
//   abort                 forces IDLE from any state
//   in_valid/in_data/in_ready     write-side handshake (ready only in FILL)
//   out_valid/out_data/out_ready  read-side handshake (valid only in DRAIN)
//   busy                  high in FILL or DRAIN
//   frame_done            one-cycle pulse after the last byte is accepted
//   bram_en/we/addr/di    BRAM port drive, bram_dout BRAM read data
//   drop_cnt              bytes offered outside FILL (optional)
//
// Optional feature macro: SRP_BUFF_DROP_CNT_EN adds the saturating drop_cnt
// port and counter; without it, in_valid outside FILL is silently ignored.
// -----------------------------------------------------------------------------
module srp_out_buff_ctrl #(
   parameter int DEPTH = 768,
   parameter int AW    = 10,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          busy,
   output logic          frame_done,
   output logic          bram_en,
   output logic          bram_we,
   output logic [AW-1:0] bram_addr,
   output logic [DW-1:0] bram_di,
   input  logic [DW-1:0] bram_dout
`ifdef SRP_BUFF_DROP_CNT_EN
   ,
   output logic [15:0]   drop_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Pointers are one bit wider than the address so rd_ptr can reach DEPTH
   // even when DEPTH == 2^AW.
   localparam logic [AW:0] PTR_ZERO  = {(AW+1){1'b0}};
   localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] PTR_LAST  = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

   state_t      state_r;
   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic        out_valid_r;

   logic        wr_issue_s;
   logic        rd_issue_s;
   logic        last_acc_s;

   assign wr_issue_s = (state_r == ST_FILL) && in_valid;
   // A new read may go out only when the output slot is empty or being freed;
   // this makes out_ready reach bram_en combinationally.
   assign rd_issue_s = (state_r == ST_DRAIN) && (rd_ptr_r < PTR_DEPTH) &&
                       (!out_valid_r || out_ready);
   // At most one byte is ever outstanding, so once every read has been issued
   // the byte on the output is address DEPTH-1.
   assign last_acc_s = (state_r == ST_DRAIN) && out_valid_r && out_ready &&
                       (rd_ptr_r == PTR_DEPTH);

   assign in_ready   = (state_r == ST_FILL);
   assign busy       = (state_r == ST_FILL) || (state_r == ST_DRAIN);
   assign frame_done = (state_r == ST_DONE);
   assign out_valid  = out_valid_r;
   assign out_data   = bram_dout;

   // BRAM port drive: write in FILL, read in DRAIN, quiet and zeroed otherwise.
   always_comb begin
      bram_en   = 1'b0;
      bram_we   = 1'b0;
      bram_addr = {AW{1'b0}};
      bram_di   = {DW{1'b0}};
      if (wr_issue_s) begin
         bram_en   = 1'b1;
         bram_we   = 1'b1;
         bram_addr = wr_ptr_r[AW-1:0];
         bram_di   = in_data;
      end else if (rd_issue_s) begin
         bram_en   = 1'b1;
         bram_we   = 1'b0;
         bram_addr = rd_ptr_r[AW-1:0];
         bram_di   = {DW{1'b0}};
      end else begin
         bram_en   = 1'b0;
         bram_we   = 1'b0;
         bram_addr = {AW{1'b0}};
         bram_di   = {DW{1'b0}};
      end
   end

   // Frame sequencer: state, write/read pointers and the output-valid flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         out_valid_r <= 1'b0;
      end else if (abort) begin
         state_r     <= ST_IDLE;
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               out_valid_r <= 1'b0;
               if (start) begin
                  state_r  <= ST_FILL;
                  wr_ptr_r <= PTR_ZERO;
               end
            end
            ST_FILL: begin
               out_valid_r <= 1'b0;
               if (wr_issue_s) begin
                  wr_ptr_r <= wr_ptr_r + PTR_ONE;
                  if (wr_ptr_r == PTR_LAST) begin
                     state_r  <= ST_DRAIN;
                     rd_ptr_r <= PTR_ZERO;
                  end
               end
            end
            ST_DRAIN: begin
               out_valid_r <= rd_issue_s || (out_valid_r && !out_ready);
               if (rd_issue_s) begin
                  rd_ptr_r <= rd_ptr_r + PTR_ONE;
               end
               if (last_acc_s) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_r     <= ST_IDLE;
               wr_ptr_r    <= PTR_ZERO;
               rd_ptr_r    <= PTR_ZERO;
               out_valid_r <= 1'b0;
            end
            default: begin
               state_r     <= ST_IDLE;
               wr_ptr_r    <= PTR_ZERO;
               rd_ptr_r    <= PTR_ZERO;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef SRP_BUFF_DROP_CNT_EN
   logic [15:0] drop_cnt_r;

   // Saturating count of bytes offered while the buffer cannot take them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_r <= 16'h0000;
      end else if (in_valid && (state_r != ST_FILL) && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
   end

   assign drop_cnt = drop_cnt_r;
`endif

endmodule
